// File: rtl/lc3b_types.sv
// Shared lc3b pipeline types used by the data-memory access stage.
//   lc3b_opcode    : 4-bit lc3b opcode encoding
//   lc3b_ipacket   : instruction packet carried down the pipeline
//   lc3b_mem_state : sequencing state of the MEM-stage access FSM
// Helper functions classify opcodes for the memory stage.
package lc3b_types;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode opcode;
  } lc3b_ipacket;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PTR    = 2'b01,
    ACCESS = 2'b10,
    HOLD   = 2'b11
  } lc3b_mem_state;

  // True for every opcode that touches data memory.
  function automatic logic is_mem_op(input lc3b_opcode op);
    case (op)
      OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI: is_mem_op = 1'b1;
      default:                                        is_mem_op = 1'b0;
    endcase
  endfunction

  // True for the two-access forms that first fetch a pointer.
  function automatic logic is_indirect(input lc3b_opcode op);
    case (op)
      OP_LDI, OP_STI: is_indirect = 1'b1;
      default:        is_indirect = 1'b0;
    endcase
  endfunction

  // True for byte-wide accesses; these keep address bit 0.
  function automatic logic is_byte_op(input lc3b_opcode op);
    case (op)
      OP_LDB, OP_STB: is_byte_op = 1'b1;
      default:        is_byte_op = 1'b0;
    endcase
  endfunction

  // True when the final access is a write.
  function automatic logic is_store_op(input lc3b_opcode op);
    case (op)
      OP_STR, OP_STB, OP_STI: is_store_op = 1'b1;
      default:                is_store_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_fmt.sv
// Combinational byte formatting for the MEM stage.
// Ports:
//   store_op, store_lane, sr_data -> wdata, byte_enable
//     store data replication and lane enables for the op entering MEM
//   load_op, load_lane, rdata     -> load_data
//     load result: LDB selects a byte and sign-extends, LDR/LDI pass the
//     word, anything else returns zero
module mem_byte_fmt
  import lc3b_types::*;
(
  input  lc3b_opcode  store_op,
  input  logic        store_lane,
  input  logic [15:0] sr_data,
  output logic [15:0] wdata,
  output logic [1:0]  byte_enable,
  input  lc3b_opcode  load_op,
  input  logic        load_lane,
  input  logic [15:0] rdata,
  output logic [15:0] load_data
);

  logic [7:0] sel_byte;

  // Store data and lane enables; byte ops enable only the addressed lane.
  always_comb begin
    wdata       = 16'h0000;
    byte_enable = 2'b00;
    case (store_op)
      OP_STB: begin
        wdata       = {sr_data[7:0], sr_data[7:0]};
        byte_enable = store_lane ? 2'b10 : 2'b01;
      end
      OP_LDB: begin
        byte_enable = store_lane ? 2'b10 : 2'b01;
      end
      OP_STR, OP_STI: begin
        wdata       = sr_data;
        byte_enable = 2'b11;
      end
      OP_LDR, OP_LDI: begin
        byte_enable = 2'b11;
      end
      default: begin
        wdata       = 16'h0000;
        byte_enable = 2'b00;
      end
    endcase
  end

  // Load result formatting.
  always_comb begin
    sel_byte  = load_lane ? rdata[15:8] : rdata[7:0];
    load_data = 16'h0000;
    case (load_op)
      OP_LDB:         load_data = {{8{sel_byte[7]}}, sel_byte};
      OP_LDR, OP_LDI: load_data = rdata;
      default:        load_data = 16'h0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_access.sv
// Data-memory access stage of the lc3b pipeline. Sequences LDR/STR/LDB/
// STB/LDI/STI transactions (including the pointer fetch of LDI/STI),
// formats byte loads/stores and freezes the pipeline while busy.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ipacket, alu_in,      instruction in MEM, effective address,
//   sr_data, stall        store data, external freeze
//   mem_stall, mem_data,  freeze request, load result (combinational),
//   misalign              misaligned word access pulse
//   dmem_*                registered request to data memory, plus
//                         dmem_rdata/dmem_resp completion inputs
// Build option: define MEM_STAGE_MISALIGN_TRAP_EN to drop odd-address word
// accesses and pulse misalign; otherwise bit 0 is silently cleared.
module mem_stage_access
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  lc3b_ipacket ipacket,
  input  logic [15:0] alu_in,
  input  logic [15:0] sr_data,
  input  logic        stall,
  output logic        mem_stall,
  output logic [15:0] mem_data,
  output logic        misalign,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp
);

  lc3b_mem_state state, state_nxt;
  lc3b_opcode    op_in, op_r, op_nxt;
  logic [15:0]   addr_nxt, wdata_nxt, held_r, held_nxt;
  logic          read_nxt, write_nxt, trap_hit;
  logic [1:0]    be_nxt;
  logic [15:0]   fmt_wdata, fmt_load;
  logic [1:0]    fmt_be;
  logic          word_misaligned, ptr_misaligned;

  assign op_in = ipacket.opcode;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign word_misaligned = !is_byte_op(op_in) && alu_in[0];
  assign ptr_misaligned  = dmem_rdata[0];
`else
  assign word_misaligned = 1'b0;
  assign ptr_misaligned  = 1'b0;
`endif

  // trap_hit is constant zero unless the trap build is selected.
  assign misalign = trap_hit;

  // Store side follows the incoming op; load side follows the captured op
  // and the lane of the address actually issued.
  mem_byte_fmt u_fmt (
    .store_op    (op_in),
    .store_lane  (alu_in[0]),
    .sr_data     (sr_data),
    .wdata       (fmt_wdata),
    .byte_enable (fmt_be),
    .load_op     (op_r),
    .load_lane   (dmem_address[0]),
    .rdata       (dmem_rdata),
    .load_data   (fmt_load)
  );

  // Next-state, request updates and stage outputs.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_r;
    addr_nxt  = dmem_address;
    wdata_nxt = dmem_wdata;
    read_nxt  = dmem_read;
    write_nxt = dmem_write;
    be_nxt    = dmem_byte_enable;
    held_nxt  = held_r;
    mem_stall = 1'b0;
    mem_data  = 16'h0000;
    trap_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem_op(op_in)) begin
          if (word_misaligned) begin
            trap_hit = 1'b1;
          end else begin
            mem_stall = 1'b1;
            op_nxt    = op_in;
            addr_nxt  = is_byte_op(op_in) ? alu_in : {alu_in[15:1], 1'b0};
            wdata_nxt = fmt_wdata;
            be_nxt    = fmt_be;
            if (is_indirect(op_in)) begin
              // Pointer fetch is always a read, even for STI.
              read_nxt  = 1'b1;
              write_nxt = 1'b0;
              state_nxt = PTR;
            end else begin
              read_nxt  = !is_store_op(op_in);
              write_nxt = is_store_op(op_in);
              state_nxt = ACCESS;
            end
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      PTR: begin
        mem_stall = 1'b1;
        if (dmem_resp) begin
          if (ptr_misaligned) begin
            trap_hit  = 1'b1;
            mem_stall = 1'b0;
            read_nxt  = 1'b0;
            write_nxt = 1'b0;
            be_nxt    = 2'b00;
            state_nxt = IDLE;
          end else begin
            addr_nxt  = {dmem_rdata[15:1], 1'b0};
            read_nxt  = (op_r == OP_LDI);
            write_nxt = (op_r == OP_STI);
            state_nxt = ACCESS;
          end
        end else begin
          state_nxt = PTR;
        end
      end
      ACCESS: begin
        if (dmem_resp) begin
          mem_data  = fmt_load;
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          be_nxt    = 2'b00;
          if (stall) begin
            // Pipeline cannot take the result yet; keep it for HOLD.
            held_nxt  = fmt_load;
            state_nxt = HOLD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          mem_stall = 1'b1;
        end
      end
      HOLD: begin
        mem_data = held_r;
        if (!stall) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request, captured-op and held-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r             <= OP_BR;
      dmem_address     <= 16'h0000;
      dmem_wdata       <= 16'h0000;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_byte_enable <= 2'b00;
      held_r           <= 16'h0000;
    end else begin
      op_r             <= op_nxt;
      dmem_address     <= addr_nxt;
      dmem_wdata       <= wdata_nxt;
      dmem_read        <= read_nxt;
      dmem_write       <= write_nxt;
      dmem_byte_enable <= be_nxt;
      held_r           <= held_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Scoreboard bench for mem_stage_access: a driver issues ops and pushes the
// expected outcome computed from a word-array memory model; a responder
// plays memory with per-access wait states; a monitor retires ops and
// compares accesses, stall cycle counts and load data.
module tb_mem_stage_access;
  import lc3b_types::*;

  logic        clk, rst_n, stall;
  lc3b_ipacket ipacket;
  logic [15:0] alu_in, sr_data, mem_data, dmem_address, dmem_wdata, dmem_rdata;
  logic        mem_stall, misalign, dmem_read, dmem_write, dmem_resp;
  logic [1:0]  dmem_byte_enable;

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } acc_t;

  typedef struct packed {
    lc3b_opcode  op;
    logic [1:0]  n_acc;
    acc_t        a0;
    acc_t        a1;
    logic [15:0] data;
    logic [7:0]  stalls;
  } exp_t;

  exp_t        exp_q[$];
  int          wait_q[$];
  acc_t        obs_q[$];
  logic [15:0] mem [0:32767];
  int          checks, errors, stall_cnt;
  bit          monitor_en, responder_en, inject_resp, aborted;

  mem_stage_access dut (
    .clk(clk), .rst_n(rst_n), .ipacket(ipacket), .alu_in(alu_in),
    .sr_data(sr_data), .stall(stall), .mem_stall(mem_stall),
    .mem_data(mem_data), .misalign(misalign), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem[int'(a >> 1)];
  endfunction

  // Reference behaviour: which accesses happen, what data comes back.
  function automatic exp_t model(input lc3b_opcode op, input logic [15:0] alu,
                                 input logic [15:0] sr, input int w1, input int w2);
    exp_t e;
    logic [15:0] ea, ptr, word;
    logic [7:0]  b;
    e = '0;
    e.op = op;
    ea = alu & 16'hFFFE;
    case (op)
      OP_LDR: begin e.n_acc = 2'd1; e.a0.addr = ea; e.data = rd(ea); end
      OP_LDB: begin
        e.n_acc = 2'd1; e.a0.addr = alu; word = rd(alu);
        b = (alu % 16'd2 == 16'd1) ? word[15:8] : word[7:0];
        e.data = (b >= 8'h80) ? (16'hFF00 | {8'h00, b}) : {8'h00, b};
      end
      OP_STR: begin
        e.n_acc = 2'd1; e.a0.addr = ea; e.a0.wr = 1'b1; e.a0.wdata = sr; e.a0.be = 2'b11;
      end
      OP_STB: begin
        e.n_acc = 2'd1; e.a0.addr = alu; e.a0.wr = 1'b1;
        e.a0.wdata = {sr[7:0], sr[7:0]};
        e.a0.be = (alu % 16'd2 == 16'd1) ? 2'b10 : 2'b01;
      end
      OP_LDI: begin
        e.n_acc = 2'd2; e.a0.addr = ea; ptr = rd(ea);
        e.a1.addr = ptr & 16'hFFFE; e.data = rd(ptr);
      end
      OP_STI: begin
        e.n_acc = 2'd2; e.a0.addr = ea; ptr = rd(ea);
        e.a1.addr = ptr & 16'hFFFE; e.a1.wr = 1'b1; e.a1.wdata = sr; e.a1.be = 2'b11;
      end
      default: e.n_acc = 2'd0;
    endcase
    if (e.n_acc == 2'd0) e.stalls = 8'd0;
    else if (e.n_acc == 2'd1) e.stalls = 8'(1 + w1);
    else e.stalls = 8'(2 + w1 + w2);
    return e;
  endfunction

  task automatic cmp_acc(input string tag, input acc_t got, input acc_t exp);
    chk({tag, "_addr"}, got.addr, exp.addr);
    chk({tag, "_write"}, got.wr, exp.wr);
    if (exp.wr) begin
      chk({tag, "_wdata"}, got.wdata, exp.wdata);
      chk({tag, "_be"}, got.be, exp.be);
    end
  endtask

  // Memory responder: one pop from wait_q per access, resp after that many waits.
  initial begin
    int cnt;
    bit busy;
    busy = 1'b0; cnt = 0; dmem_resp = 1'b0; dmem_rdata = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (!responder_en) begin
        busy = 1'b0; dmem_resp = inject_resp; dmem_rdata = 16'h0000;
      end else begin
        if (dmem_resp) begin dmem_resp = 1'b0; busy = 1'b0; end
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            dmem_resp = 1'b1;
            dmem_rdata = dmem_read ? mem[dmem_address[15:1]] : 16'($urandom);
          end
        end else if (dmem_read || dmem_write) begin
          if (wait_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_request addr=%h expected no request", dmem_address);
            cnt = 0;
          end else begin
            cnt = wait_q.pop_front();
          end
          busy = 1'b1;
          if (cnt == 0) begin
            dmem_resp = 1'b1;
            dmem_rdata = dmem_read ? mem[dmem_address[15:1]] : 16'($urandom);
          end
        end
      end
    end
  end

  // Monitor: counts stall cycles, records completed accesses, retires ops.
  initial begin
    exp_t cur;
    acc_t a;
    forever begin
      @(negedge clk);
      if (!monitor_en) begin
        stall_cnt = 0; obs_q.delete();
      end else begin
        if (mem_stall) stall_cnt++;
        if (dmem_resp && (dmem_read || dmem_write)) begin
          a.addr = dmem_address; a.wr = dmem_write; a.wdata = dmem_wdata; a.be = dmem_byte_enable;
          obs_q.push_back(a);
        end
        if (!mem_stall) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL no_expectation mem_stall=0 with empty scoreboard");
          end else begin
            cur = exp_q[0];
            if (!stall || obs_q.size() >= int'(cur.n_acc))
              chk("mem_data", mem_data, cur.data);
            if (!stall) begin
              chk("stall_cycles", stall_cnt, 32'(cur.stalls));
              chk("access_count", obs_q.size(), 32'(cur.n_acc));
              chk("misalign", misalign, 32'd0);
              if (obs_q.size() > 0 && cur.n_acc > 2'd0) cmp_acc("acc0", obs_q[0], cur.a0);
              if (obs_q.size() > 1 && cur.n_acc > 2'd1) cmp_acc("acc1", obs_q[1], cur.a1);
              void'(exp_q.pop_front());
              obs_q.delete();
              stall_cnt = 0;
            end
          end
        end
      end
    end
  end

  function automatic logic pick_stall(input int mode, input int k);
    if (mode == 1) return ($urandom_range(0, 3) == 0);
    if (mode == 2) return (k < 4);
    return 1'b0;
  endfunction

  // mode: 0 no external stall, 1 random stall, 2 stall held for the first 4 cycles.
  task automatic run_op(input lc3b_opcode op, input logic [15:0] alu, input logic [15:0] sr,
                        input int w1, input int w2, input int mode);
    exp_t e;
    int k;
    if (aborted) return;
    @(posedge clk); #1;
    e = model(op, alu, sr, w1, w2);
    exp_q.push_back(e);
    if (e.n_acc >= 2'd1) wait_q.push_back(w1);
    if (e.n_acc == 2'd2) wait_q.push_back(w2);
    ipacket.opcode = op; alu_in = alu; sr_data = sr;
    k = 0;
    stall = pick_stall(mode, k);
    forever begin
      @(negedge clk);
      if (!mem_stall && !stall) break;
      k++;
      if (k > 80) begin
        checks++; errors++; aborted = 1'b1;
        $display("FAIL retire_timeout op=%0d cycles=%0d limit=80", op, k);
        break;
      end
      @(posedge clk); #1;
      stall = pick_stall(mode, k);
    end
  endtask

  initial begin
    lc3b_opcode mem_ops [6];
    lc3b_opcode op;
    checks = 0; errors = 0; stall_cnt = 0;
    monitor_en = 1'b0; responder_en = 1'b0; inject_resp = 1'b0; aborted = 1'b0;
    mem_ops = '{OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI};
    rst_n = 1'b0; stall = 1'b0; ipacket.opcode = OP_ADD; alu_in = 16'h0000; sr_data = 16'h0000;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[16'h3004 >> 1] = 16'hBEEF;
    mem[16'h2000 >> 1] = 16'h80FF;
    mem[16'h4000 >> 1] = 16'h5002;
    mem[16'h5002 >> 1] = 16'h00AA;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", dmem_read, 32'd0);
    chk("rst_write", dmem_write, 32'd0);
    chk("rst_addr", dmem_address, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_be", dmem_byte_enable, 32'd0);
    chk("rst_misalign", misalign, 32'd0);
    chk("rst_mem_stall", mem_stall, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of an STR access, then a late response.
    @(posedge clk); #1;
    ipacket.opcode = OP_STR; alu_in = 16'h1235; sr_data = 16'hCAFE;
    @(negedge clk);
    chk("str_idle_stall", mem_stall, 32'd1);
    @(posedge clk); #1;
    chk("str_write", dmem_write, 32'd1);
    chk("str_addr", dmem_address, 32'h1234);
    chk("str_wdata", dmem_wdata, 32'hCAFE);
    chk("str_be", dmem_byte_enable, 32'd3);
    @(negedge clk);
    chk("str_wait_stall", mem_stall, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_write", dmem_write, 32'd0);
    chk("rst_mid_addr", dmem_address, 32'd0);
    ipacket.opcode = OP_ADD;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    inject_resp = 1'b1;
    @(negedge clk);
    chk("late_resp_stall", mem_stall, 32'd0);
    chk("late_resp_write", dmem_write, 32'd0);
    inject_resp = 1'b0;
    @(posedge clk); #1;
    chk("late_resp_read_after", dmem_read, 32'd0);
    chk("late_resp_write_after", dmem_write, 32'd0);
    @(negedge clk);
    monitor_en = 1'b1;
    responder_en = 1'b1;

    // Directed cases.
    run_op(OP_LDR, 16'h3005, 16'h0000, 0, 0, 0);
    run_op(OP_LDB, 16'h2001, 16'h0000, 0, 0, 0);
    run_op(OP_LDB, 16'h2000, 16'h0000, 0, 0, 0);
    run_op(OP_STB, 16'h2001, 16'h1234, 0, 0, 0);
    run_op(OP_LDI, 16'h4000, 16'h0000, 2, 2, 0);
    run_op(OP_LDR, 16'h3005, 16'h0000, 0, 0, 2);
    run_op(OP_STI, 16'h4001, 16'h9876, 1, 0, 0);
    run_op(OP_ADD, 16'h3005, 16'h0000, 0, 0, 0);
    run_op(OP_LDR, 16'h3004, 16'h0000, 0, 0, 0);
    run_op(OP_STR, 16'h3004, 16'h5555, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) op = lc3b_opcode'($urandom_range(0, 15));
      else op = mem_ops[$urandom_range(0, 5)];
      run_op(op, 16'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1);
    end

    @(posedge clk); #1;
    monitor_en = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("waits_consumed", wait_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
